function_eval_unit: RTL and testbench
=====================================

# function_eval_unit

Parametrised, sequential successor to the combinational three-operand function-call tests: evaluates a selectable function over NOPS operands of WIDTH bits, streamed one operand per beat. Serves as the reference evaluator the function-call regression benches compare against, and as a reusable arithmetic leaf in the test harness. The input and output sides each use a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥1)
- NOPS, 3, operands per operation (≥2)
- RW, WIDTH+$clog2(NOPS), result width (derived, not overridable)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept an operand beat
- in_data  input  WIDTH  operand value
- in_mode  input  2  function select; sampled on the first beat only
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  RW  result
- out_err  output  1  illegal mode flag, qualified by out_valid

## Operation
- A beat transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
- FSM states:
  - IDLE: first beat latches in_mode and beat 0, sets cnt=1, moves to ACCUM.
  - ACCUM: each beat increments cnt. The beat with cnt==NOPS-1 moves to DONE.
  - DONE: holds the result until transfer, then returns to IDLE.
- Modes:
  - 0 SUM: zero-extended sum of all operands. Full RW width, so it never wraps.
  - 1 RSUM: sum of the reduction-AND (&) of each operand. The result lies in 0..NOPS.
  - 2 SEL: operand0 != 0 ? operand1 : operand2, zero-extended. Operands 3..NOPS-1 are consumed and ignored.
  - 3: illegal. All beats are still consumed; out_data=0 and out_err=1.
- in_ready = (state != DONE). No beats are accepted while a result is pending.
- out_data and out_err are stable while out_valid && !out_ready.

## Timing
- Reset values: state IDLE, cnt 0, accumulator 0, in_ready 1, out_valid 0, out_data 0, out_err 0.
- Latency: if the first beat is accepted at cycle t and beats are back-to-back, the last beat is accepted at t+NOPS-1. out_valid is high from t+NOPS (registered).
- Throughput: one result per NOPS+1 cycles when out_ready is held high.
- Input gaps (in_valid low) stall the FSM with no state change.
- Result-transfer cycle: in_ready is low that cycle, and the next first beat is accepted no earlier than the following cycle.
- rst asserted mid-operation: the partial operation is discarded immediately (asynchronously) and all outputs return to their reset values. The next operation starts clean.
- in_mode on non-first beats is ignored, even if it changes.

## Structure
- Shared package function_eval_pkg holds:
  - the mode enum: MODE_SUM=0, MODE_RSUM=1, MODE_SEL=2, MODE_ILL=3
  - the FSM state enum: IDLE, ACCUM, DONE
- One natural sub-module, function_eval_datapath:
  - contains the per-beat combine logic (add / reduction-AND-add / select capture), the accumulator register, and the operand-index decode for SEL
  - control FSM and handshakes stay in the top level.

## Test plan
With WIDTH=8, NOPS=3 unless stated otherwise:
- SUM, beats 0xFF, 0xFF, 0xFF back-to-back, out_ready=1 -> out_data=765 (0x2FD), out_err=0. out_valid asserted exactly 3 cycles after the first beat.
- RSUM, beats 0xFF, 0x01, 0xFF -> out_data=2. Then SEL, beats 0x00, 0x11, 0x22 -> 0x22. Then SEL, beats 0x05, 0x11, 0x22 -> 0x11.
- Mode 3, beats 1, 2, 3 -> out_data=0, out_err=1. A following SUM 1, 2, 3 -> out_data=6, out_err=0.
- Backpressure: SUM 10, 20, 30 with out_ready low for 5 cycles -> out_data=60 held stable and in_ready=0 throughout. Beats offered meanwhile are not consumed. The result transfers on the first out_ready cycle.
- Reset mid-op: SUM, 2 beats, assert rst for 1 cycle -> outputs at reset values. A fresh SUM 4, 5, 6 -> out_data=15.
- NOPS=5, WIDTH=4: SUM of 0xF ×5 with random in_valid gaps -> out_data=75 (RW=7). The mode change on beat 2 is ignored.

Source files
------------

// File: rtl/function_eval_pkg.sv
// rtl/function_eval_pkg.sv - shared mode and FSM state types for the function evaluator
package function_eval_pkg;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_RSUM = 2'd1,
    MODE_SEL  = 2'd2,
    MODE_ILL  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/function_eval_datapath.sv
// rtl/function_eval_datapath.sv - per-beat combine logic and accumulator register
module function_eval_datapath
  import function_eval_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NOPS  = 3,
  parameter int RW    = WIDTH + $clog2(NOPS),
  parameter int CW    = $clog2(NOPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat_fire,
  input  mode_e            mode,
  input  logic [CW-1:0]    idx,
  input  logic [WIDTH-1:0] data,
  output logic [RW-1:0]    acc
);

  logic [RW-1:0] acc_q, acc_d;
  logic          sel_nz_q, sel_nz_d;
  logic          first;
  logic [RW-1:0] base;

  assign first = (idx == '0);
  assign base  = first ? '0 : acc_q;
  assign acc   = acc_q;

  // Beat 0 restarts the accumulation, so no explicit clear is needed between operations.
  always_comb begin
    acc_d    = acc_q;
    sel_nz_d = sel_nz_q;
    if (beat_fire) begin
      case (mode)
        MODE_SUM:  acc_d = base + RW'(data);
        MODE_RSUM: acc_d = base + RW'(&data);
        MODE_SEL: begin
          acc_d = base;
          if (first) begin
            sel_nz_d = (data != '0);
          end else if ((int'(idx) == 1 && sel_nz_q) || (int'(idx) == 2 && !sel_nz_q)) begin
            acc_d = RW'(data);
          end
        end
        default:   acc_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      sel_nz_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sel_nz_q <= sel_nz_d;
    end
  end

endmodule

// File: rtl/function_eval_unit.sv
// rtl/function_eval_unit.sv - streamed NOPS-operand function evaluator with valid/ready handshakes
module function_eval_unit
  import function_eval_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  NOPS  = 3,
  localparam int RW    = WIDTH + $clog2(NOPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    out_data,
  output logic             out_err
);

  localparam int CW = $clog2(NOPS);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mode_e         mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic          out_err_q, out_err_d;
  logic          in_fire, out_fire;
  mode_e         beat_mode;
  logic [CW-1:0] beat_idx;

  assign in_ready  = (state_q != DONE);
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;

  // in_mode only matters on the first beat; later beats use the latched copy.
  assign beat_mode = (state_q == IDLE) ? mode_e'(in_mode) : mode_q;
  assign beat_idx  = (state_q == IDLE) ? '0 : cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          mode_d  = mode_e'(in_mode);
          cnt_d   = CW'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          if (cnt_q == CW'(NOPS - 1)) begin
            cnt_d       = '0;
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_err_d   = (mode_q == MODE_ILL);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (out_fire) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_SUM;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  function_eval_datapath #(
    .WIDTH(WIDTH),
    .NOPS (NOPS),
    .RW   (RW),
    .CW   (CW)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .beat_fire(in_fire),
    .mode     (beat_mode),
    .idx      (beat_idx),
    .data     (in_data),
    .acc      (out_data)
  );

endmodule

// File: tb/tb_function_eval_unit.sv
// tb/tb_function_eval_unit.sv - randomized and directed bench for function_eval_unit
module tb_function_eval_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [7:0] a_in_data;
  logic [1:0] a_in_mode;
  logic [9:0] a_out_data;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [3:0] b_in_data;
  logic [1:0] b_in_mode;
  logic [6:0] b_out_data;

  function_eval_unit #(.WIDTH(8), .NOPS(3)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err)
  );

  function_eval_unit #(.WIDTH(4), .NOPS(5)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: function value straight from the mode definitions, in integer arithmetic.
  function automatic int model(input int mode, input int w, input int n, input int ops[8]);
    int r;
    int all_ones;
    r = 0;
    all_ones = (1 << w) - 1;
    case (mode)
      0: for (int i = 0; i < n; i++) r += ops[i];
      1: for (int i = 0; i < n; i++) r += (ops[i] == all_ones) ? 1 : 0;
      2: r = (ops[0] != 0) ? ops[1] : ops[2];
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic int pick8();
    int r;
    r = $urandom_range(3);
    if (r == 0) return 255;
    if (r == 1) return 0;
    return $urandom_range(255);
  endfunction

  task automatic op_a(input int mode, input int o0, input int o1, input int o2,
                      input int gap_pct, input int stall, input string tag);
    int ops[8];
    int exp_v;
    int first_c;
    int bound;
    bit gaps;
    gaps = 1'b0;
    first_c = 0;
    ops = '{default: 0};
    ops[0] = o0; ops[1] = o1; ops[2] = o2;
    exp_v = model(mode, 8, 3, ops);
    a_out_ready = (stall == 0);
    for (int i = 0; i < 3; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        a_in_valid = 1'b0;
        gaps = 1'b1;
        @(negedge clk);
      end
      a_in_valid = 1'b1;
      a_in_data  = ops[i][7:0];
      a_in_mode  = (i == 0) ? mode[1:0] : 2'($urandom);
      chk({tag, "_in_ready"}, a_in_ready, 1);
      if (i == 0) first_c = cyc;
      if (i == 2) chk({tag, "_valid_early"}, a_out_valid, 0);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    if (!gaps) begin
      chk({tag, "_latency_valid"}, a_out_valid, 1);
      chk({tag, "_latency"}, cyc - first_c, 3);
    end
    bound = 0;
    while (!a_out_valid && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    chk({tag, "_valid"}, a_out_valid, 1);
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_hold_data"}, a_out_data, exp_v);
      chk({tag, "_hold_in_ready"}, a_in_ready, 0);
      a_in_valid = 1'b1;
      a_in_data  = 8'hA5;
      @(negedge clk);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    chk({tag, "_data"}, a_out_data, exp_v);
    chk({tag, "_err"}, a_out_err, (mode == 3) ? 1 : 0);
    @(negedge clk);
    chk({tag, "_xfer_valid"}, a_out_valid, 0);
    chk({tag, "_xfer_in_ready"}, a_in_ready, 1);
  endtask

  task automatic op_b(input int mode, input int ops[8], input int gap_pct, input string tag);
    int exp_v;
    int bound;
    exp_v = model(mode, 4, 5, ops);
    b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        b_in_valid = 1'b0;
        @(negedge clk);
      end
      b_in_valid = 1'b1;
      b_in_data  = ops[i][3:0];
      b_in_mode  = (i == 0) ? mode[1:0] : 2'(mode + i);
      chk({tag, "_in_ready"}, b_in_ready, 1);
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    bound = 0;
    while (!b_out_valid && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    chk({tag, "_valid"}, b_out_valid, 1);
    chk({tag, "_data"}, b_out_data, exp_v);
    chk({tag, "_err"}, b_out_err, (mode == 3) ? 1 : 0);
    @(negedge clk);
    chk({tag, "_xfer_valid"}, b_out_valid, 0);
  endtask

  initial begin
    int ops[8];
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_err", a_out_err, 0);
    rst = 1'b0;
    @(negedge clk);

    op_a(0, 8'hFF, 8'hFF, 8'hFF, 0, 0, "sum_ff");
    op_a(1, 8'hFF, 8'h01, 8'hFF, 0, 0, "rsum");
    op_a(2, 8'h00, 8'h11, 8'h22, 0, 0, "sel_zero");
    op_a(2, 8'h05, 8'h11, 8'h22, 0, 0, "sel_nz");
    op_a(3, 1, 2, 3, 0, 0, "illegal");
    op_a(0, 1, 2, 3, 0, 0, "sum_after_ill");
    op_a(0, 10, 20, 30, 0, 5, "backpressure");

    a_in_valid = 1'b1; a_in_mode = 2'd0; a_in_data = 8'd7;
    @(negedge clk);
    a_in_data = 8'd8;
    @(negedge clk);
    a_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", a_in_ready, 1);
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_out_data", a_out_data, 0);
    chk("midrst_out_err", a_out_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op_a(0, 4, 5, 6, 0, 0, "sum_after_rst");

    for (int k = 0; k < 40; k++) begin
      op_a($urandom_range(3), pick8(), pick8(), pick8(), 30, $urandom_range(3), "rand_a");
    end

    ops = '{default: 0};
    for (int i = 0; i < 5; i++) ops[i] = 15;
    op_b(0, ops, 40, "b_sum_f");
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 5; i++) ops[i] = ($urandom_range(2) == 0) ? 15 : $urandom_range(15);
      op_b($urandom_range(3), ops, 25, "rand_b");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
